wm8731_cfg_seq: RTL and testbench

Configuration sequencer for the WM8731 audio codec. It sits between the system reset/control logic and the I2C master `i2cc`. After reset, or on request, it walks a fixed internal table of codec register writes. For each entry it presents the 24-bit I2C frame `{device address, register word}` to the master, pulses the master's write strobe, and tracks the `i2c_idle` handshake through to completion.

---
 rtl/wm8731_cfg_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_wm8731_cfg_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_cfg_seq.sv
// WM8731 codec configuration sequencer.
// After reset, or on `start` in the done state, it waits for the codec to power up.
// It then writes a fixed 12-entry register table through the i2cc master. Each write
// follows the i2c_idle handshake.
// Optional headphone volume updates are compiled in with `define WM8731_VOL_UPD_EN.
module wm8731_cfg_seq #(
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter logic [15:0] STARTUP_CYCLES = 16'd50000,
    parameter logic [7:0]  GAP_CYCLES     = 8'd16,
    parameter logic [2:0]  ACCEPT_TO      = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_idle,
    output logic [23:0] i2c_din,
    output logic        wr_i2c,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic [3:0]  cfg_idx,
    input  logic        vol_req,
    input  logic [6:0]  vol_val,
    output logic        vol_ack
);

    typedef enum logic [3:0] {
        StPwr, StLoad, StAcc, StXfer, StGap, StDone, StVload, StVacc, StVxfer
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] din_q, din_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;

`ifdef WM8731_VOL_UPD_EN
    logic        pend_q, pend_d;
    logic [6:0]  vval_q, vval_d;
`else
    logic        unused_vol;
    assign unused_vol = ^{vol_req, vol_val};
`endif

    // Register word {reg[6:0], data[8:0]} for each table entry
    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C10;
            4'd2:    w = 16'h0017;
            4'd3:    w = 16'h0217;
            4'd4:    w = 16'h0479;
            4'd5:    w = 16'h0679;
            4'd6:    w = 16'h0812;
            4'd7:    w = 16'h0A00;
            4'd8:    w = 16'h0E0A;
            4'd9:    w = 16'h1000;
            4'd10:   w = 16'h1201;
            4'd11:   w = 16'h0C00;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    assign cnt_inc = cnt_q + 16'd1;

    // Next-state, frame and strobe decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        din_d   = din_q;
        wr_d    = 1'b0;
        ack_d   = 1'b0;
        done_d  = done_q;
`ifdef WM8731_VOL_UPD_EN
        pend_d  = pend_q;
        vval_d  = vval_q;
        // A newer request overwrites the captured volume code
        if (vol_req) begin
            pend_d = 1'b1;
            vval_d = vol_val;
        end
`endif
        case (state_q)
            StPwr: begin
                if (cnt_inc >= STARTUP_CYCLES) begin
                    state_d = StLoad;
                    din_d   = {DEV_ADDR, cfg_word(idx_q)};
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StLoad: begin
                if (i2c_idle) begin
                    wr_d    = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                // Master never left idle: the strobe was missed, issue it again
                if (!i2c_idle) begin
                    state_d = StXfer;
                end else if (cnt_inc >= {13'd0, ACCEPT_TO}) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StXfer: begin
                if (i2c_idle) begin
                    cnt_d   = 16'd0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_inc >= {8'd0, GAP_CYCLES}) begin
                    if (idx_q == 4'd11) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        din_d   = {DEV_ADDR, cfg_word(idx_q + 4'd1)};
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                // start has priority; a pending volume write waits for the new run
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = 4'd0;
                    cnt_d   = 16'd0;
                    state_d = StPwr;
                end
`ifdef WM8731_VOL_UPD_EN
                else if (pend_q) begin
                    pend_d  = vol_req;
                    din_d   = {DEV_ADDR, 7'h02, 1'b1, 1'b0, vval_q};
                    state_d = StVload;
                end
`endif
            end
`ifdef WM8731_VOL_UPD_EN
            StVload: begin
                if (i2c_idle) begin
                    wr_d    = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = StVacc;
                end
            end
            StVacc: begin
                if (!i2c_idle) begin
                    state_d = StVxfer;
                end else if (cnt_inc >= {13'd0, ACCEPT_TO}) begin
                    state_d = StVload;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StVxfer: begin
                if (i2c_idle) begin
                    ack_d   = 1'b1;
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StPwr;
        endcase
        busy_d = (state_d != StDone);
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPwr;
            cnt_q   <= 16'd0;
            idx_q   <= 4'd0;
            din_q   <= 24'h0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

`ifdef WM8731_VOL_UPD_EN
    // Pending volume request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            vval_q <= 7'd0;
        end else begin
            pend_q <= pend_d;
            vval_q <= vval_d;
        end
    end
`endif

    assign i2c_din  = din_q;
    assign wr_i2c   = wr_q;
    assign cfg_busy = busy_q;
    assign cfg_done = done_q;
    assign cfg_idx  = idx_q;
    assign vol_ack  = ack_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Directed bench for wm8731_cfg_seq with a small i2cc behavioural model.
// Covers the volume path when WM8731_VOL_UPD_EN is defined.
module tb_wm8731_cfg_seq;

    localparam int STARTUP   = 20;
    localparam int GAP       = 4;
    localparam int ACC_TO    = 4;
    localparam int XFER_LEN  = 6;
    localparam int STALL_LEN = 500;
    localparam logic [23:0] EXP_FRAMES [12] = '{
        24'h341E00, 24'h340C10, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
        24'h340812, 24'h340A00, 24'h340E0A, 24'h341000, 24'h341201, 24'h340C00
    };

    logic        clk;
    logic        reset;
    logic        start;
    logic        i2c_idle;
    logic [23:0] i2c_din;
    logic        wr_i2c;
    logic        cfg_busy;
    logic        cfg_done;
    logic [3:0]  cfg_idx;
    logic        vol_req;
    logic [6:0]  vol_val;
    logic        vol_ack;

    wm8731_cfg_seq #(
        .DEV_ADDR       (8'h34),
        .STARTUP_CYCLES (16'd20),
        .GAP_CYCLES     (8'd4),
        .ACCEPT_TO      (3'd4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .i2c_idle (i2c_idle),
        .i2c_din  (i2c_din),
        .wr_i2c   (wr_i2c),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_idx  (cfg_idx),
        .vol_req  (vol_req),
        .vol_val  (vol_val),
        .vol_ack  (vol_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests, fails;
    int cyc, rel, vol_at, ignore_cnt, busy_left, stall_left;
    int rise_cyc, min_gap, vol_ack_cnt, n, bad;
    bit rise_valid, xfer_active, stall_arm, prev_wr;
    logic [23:0] prev_din;
    logic [6:0]  vol_v;
    int          all_cyc[$];
    logic [23:0] all_din[$];
    logic [3:0]  all_idx[$];
    logic [23:0] acc_din[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then update the i2cc model
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (vol_ack) vol_ack_cnt++;
        if (reset) begin
            busy_left = 0; stall_left = 0; prev_wr = 0; xfer_active = 0;
        end else if (prev_wr) begin
            if (ignore_cnt > 0) ignore_cnt--;
            else begin
                acc_din.push_back(prev_din);
                busy_left = XFER_LEN;
                xfer_active = 1;
            end
        end
        if (stall_arm && !reset && cfg_idx == 4'd3) begin
            stall_left = STALL_LEN;
            stall_arm = 0;
        end
        if (wr_i2c) begin
            chk("strobe_while_idle", 32'(i2c_idle), 32'd1);
            all_cyc.push_back(cyc);
            all_din.push_back(i2c_din);
            all_idx.push_back(cfg_idx);
            if (rise_valid && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
        end
        prev_wr = wr_i2c;
        prev_din = i2c_din;
        if (reset) i2c_idle = 1'b1;
        else if (stall_left > 0) begin stall_left--; i2c_idle = 1'b0; end
        else if (busy_left > 0) begin busy_left--; i2c_idle = 1'b0; end
        else begin
            if (xfer_active) begin rise_cyc = cyc; rise_valid = 1; xfer_active = 0; end
            i2c_idle = 1'b1;
        end
        vol_req = (cyc == vol_at);
        vol_val = vol_v;
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, 32'(acc_din.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_frame%0d", tag, i),
                (i < acc_din.size()) ? {8'd0, acc_din[i]} : 32'hFFFF_FFFF,
                {8'd0, EXP_FRAMES[i]});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr"},   32'(wr_i2c),   32'd0);
        chk({tag, "_din"},  32'(i2c_din),  32'd0);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_idx"},  32'(cfg_idx),  32'd0);
        chk({tag, "_ack"},  32'(vol_ack),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; cyc = 0; rel = 0; vol_at = -1; ignore_cnt = 0;
        busy_left = 0; stall_left = 0; rise_cyc = 0; min_gap = 1000; vol_ack_cnt = 0;
        rise_valid = 0; xfer_active = 0; stall_arm = 0; prev_wr = 0; prev_din = '0;
        vol_v = 7'd0;
        reset = 1'b1; start = 1'b0; i2c_idle = 1'b1; vol_req = 1'b0; vol_val = 7'd0;

        // Reset state
        repeat (3) step();
        check_reset("rst");

        // Boot: first strobe ignored by the master, stall at entry 3, volume request at 30
        ignore_cnt = 1; stall_arm = 1; vol_v = 7'h60;
        reset = 1'b0; rel = cyc; vol_at = rel + 29;
        step();
        chk("busy_after_release", 32'(cfg_busy), 32'd1);
        for (int k = 0; k < 200 && all_cyc.size() < 2; k++) step();
        chk("reissue_seen", 32'(all_cyc.size() >= 2), 32'd1);
        if (all_cyc.size() >= 2) begin
            chk("first_strobe_delay", 32'(all_cyc[0] - rel), 32'(STARTUP + 1));
            chk("first_frame", {8'd0, all_din[0]}, 32'h341E00);
            chk("reissue_frame", {8'd0, all_din[1]}, 32'h341E00);
            chk("reissue_idx", 32'(all_idx[1]), 32'd0);
            chk("reissue_spacing",
                32'((all_cyc[1] - all_cyc[0]) >= ACC_TO && (all_cyc[1] - all_cyc[0]) <= ACC_TO + 2),
                32'd1);
        end
        for (int k = 0; k < 2000 && stall_left == 0; k++) step();
        chk("stall_started", 32'(stall_left > 0), 32'd1);
        n = all_cyc.size(); bad = 0;
        for (int k = 0; k < STALL_LEN + 10 && stall_left > 0; k++) begin
            step();
            if (i2c_din !== 24'h340217) bad++;
        end
        chk("stall_no_strobe", 32'(all_cyc.size()), 32'(n));
        chk("stall_din_stable", 32'(bad), 32'd0);
        chk("stall_idx", 32'(cfg_idx), 32'd3);
        start = 1'b1; step(); start = 1'b0;   // must be ignored while busy
        for (int k = 0; k < 3000 && !cfg_done; k++) step();
        chk("boot_done", 32'(cfg_done), 32'd1);
        chk("boot_busy_low", 32'(cfg_busy), 32'd0);
        chk("boot_idx", 32'(cfg_idx), 32'd11);
        check_frames("boot");
        n = all_cyc.size();
`ifdef WM8731_VOL_UPD_EN
        for (int k = 0; k < 200 && all_cyc.size() == n; k++) step();
        chk("vol_frame", (all_cyc.size() > n) ? {8'd0, all_din[n]} : 32'hFFFF_FFFF, 32'h340560);
        for (int k = 0; k < 200 && vol_ack_cnt == 0; k++) step();
        repeat (20) step();
        chk("vol_ack_once", 32'(vol_ack_cnt), 32'd1);
        chk("vol_done_held", 32'(cfg_done), 32'd1);
        chk("vol_busy_low", 32'(cfg_busy), 32'd0);
`else
        repeat (100) step();
        chk("novol_no_strobe", 32'(all_cyc.size()), 32'(n));
        chk("novol_no_ack", 32'(vol_ack_cnt), 32'd0);
`endif

        // Restart, then reset in the middle of entry 6
        acc_din.delete();
        start = 1'b1; step(); start = 1'b0;
        chk("start_clears_done", 32'(cfg_done), 32'd0);
        chk("start_idx", 32'(cfg_idx), 32'd0);
        chk("start_busy", 32'(cfg_busy), 32'd1);
        for (int k = 0; k < 3000 && !(cfg_idx == 4'd6 && !i2c_idle); k++) step();
        chk("reached_entry6", 32'(cfg_idx), 32'd6);
        reset = 1'b1;
        step();
        check_reset("midrst");
        step();
        reset = 1'b0; rel = cyc; n = all_cyc.size(); acc_din.delete();
        for (int k = 0; k < 200 && all_cyc.size() == n; k++) step();
        chk("restart_delay", (all_cyc.size() > n) ? 32'(all_cyc[n] - rel) : 32'hFFFF_FFFF,
            32'(STARTUP + 1));
        chk("restart_frame", (all_cyc.size() > n) ? {8'd0, all_din[n]} : 32'hFFFF_FFFF,
            32'h341E00);
        for (int k = 0; k < 3000 && !cfg_done; k++) step();
        check_frames("reboot");

        // start and a volume request in the same done cycle: sequence first
        acc_din.delete(); n = all_cyc.size();
        vol_v = 7'h3A; vol_val = 7'h3A; vol_req = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("combo_start_wins", 32'(cfg_done), 32'd0);
        for (int k = 0; k < 3000 && !cfg_done; k++) step();
        check_frames("combo");
`ifdef WM8731_VOL_UPD_EN
        for (int k = 0; k < 200 && all_cyc.size() <= n + 12; k++) step();
        chk("combo_vol_frame",
            (all_cyc.size() > n + 12) ? {8'd0, all_din[n + 12]} : 32'hFFFF_FFFF, 32'h34053A);
        for (int k = 0; k < 200 && vol_ack_cnt < 2; k++) step();
        repeat (20) step();
        chk("combo_vol_ack", 32'(vol_ack_cnt), 32'd2);
`else
        repeat (100) step();
        chk("combo_no_vol_strobe", 32'(all_cyc.size()), 32'(n + 12));
        chk("combo_no_ack", 32'(vol_ack_cnt), 32'd0);
`endif
        chk("min_gap", 32'(min_gap >= GAP), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
